// File: rtl/axi_lat_mem_if.sv
// AXI-style bus bundle for axi_lat_mem: read address/data and write
// address/data/response channels. The memory side uses the slave modport
// and the requester side uses the master modport.
interface axi_lat_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [ID_WIDTH-1:0]   ar_id;

  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_last;
  logic [1:0]            r_resp;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [ID_WIDTH-1:0]   aw_id;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_id,
    output ar_ready,
    output r_valid, r_data, r_id, r_last, r_resp,
    input  r_ready,
    input  aw_valid, aw_addr, aw_len, aw_id,
    output aw_ready,
    input  w_valid, w_data, w_last,
    output w_ready,
    output b_valid, b_id,
    input  b_ready
  );

  modport master (
    output ar_valid, ar_addr, ar_len, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_id, r_last, r_resp,
    output r_ready,
    output aw_valid, aw_addr, aw_len, aw_id,
    input  aw_ready,
    output w_valid, w_data, w_last,
    input  w_ready,
    input  b_valid, b_id,
    output b_ready
  );
endinterface

// File: rtl/axi_lat_mem.sv
// axi_lat_mem: word-addressed memory behind an AXI-like bus with a
// configurable per-burst read latency. Read requests queue in a small FIFO
// and are served strictly in acceptance order; writes run through a
// three-state FSM. Optional address-window error injection is enabled by
// defining AXI_LAT_MEM_ERR_INJ_EN (adds err_bar/err_limit inputs).
module axi_lat_mem #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 8,
  parameter int LOG_AR_DEPTH = 2,
  parameter int LAT_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LAT_WIDTH-1:0]  cfg_rd_latency,
`ifdef AXI_LAT_MEM_ERR_INJ_EN
  input  logic [ADDR_WIDTH-1:0] err_bar,
  input  logic [ADDR_WIDTH-1:0] err_limit,
`endif
  axi_lat_mem_if.slave          bus
);
  localparam int DEPTH     = 2 ** LOG_AR_DEPTH;
  localparam int MEM_WORDS = 2 ** ADDR_WIDTH;
  localparam int CNT_W     = LOG_AR_DEPTH + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0]   fifo_addr [DEPTH];
  logic [7:0]              fifo_len  [DEPTH];
  logic [ID_WIDTH-1:0]     fifo_id   [DEPTH];
  logic [LAT_WIDTH-1:0]    fifo_lat  [DEPTH];
  logic [LOG_AR_DEPTH-1:0] wr_ptr, rd_ptr, head_ptr;
  logic [CNT_W-1:0]        count, count_rem;

  logic push, pop, start, launch, advance, load, beat_err, ar_ready_c;

  logic [ADDR_WIDTH-1:0] nh_addr, l_addr, rd_addr, nxt_addr;
  logic [7:0]            nh_len, l_len, beat_idx, cur_len;
  logic [ID_WIDTH-1:0]   nh_id, l_id;
  logic [LAT_WIDTH-1:0]  nh_lat, wait_cnt;

  logic                  vld_p1, last_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [ID_WIDTH-1:0]   id_p1;
  logic [1:0]            resp_p1;

  wstate_t               wstate, wstate_nx;
  logic                  aw_ready_w, w_ready_w, b_valid_w;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ID_WIDTH-1:0]   bid_q;

  // Burst length is not needed on the write side: w_last ends the burst.
  logic unused_aw_len;
  assign unused_aw_len = ^bus.aw_len;

`ifdef AXI_LAT_MEM_ERR_INJ_EN
  function automatic logic out_of_window(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [ADDR_WIDTH-1:0] lo,
                                         input logic [ADDR_WIDTH-1:0] hi);
    return !((a >= lo) && (a < hi));
  endfunction
  assign beat_err = out_of_window(rd_addr, err_bar, err_limit);
`else
  assign beat_err = 1'b0;
`endif

  // Read request FIFO bookkeeping; ar_ready depends only on the count register.
  assign ar_ready_c = (count < CNT_W'(DEPTH));
  assign push       = bus.ar_valid && ar_ready_c;
  assign pop        = vld_p1 && bus.r_ready && last_p1;
  assign advance    = vld_p1 && bus.r_ready && !last_p1;
  assign count_rem  = count - CNT_W'(pop);
  assign head_ptr   = pop ? rd_ptr + LOG_AR_DEPTH'(1) : rd_ptr;
  // A new head appears when the queue was empty or the old head retires,
  // and something (stored or arriving this cycle) is there to take its place.
  assign start      = ((count == '0) || pop) && ((count_rem != '0) || push);

  // Select the entry that becomes head: bypass the incoming request when nothing else remains.
  always_comb begin
    if (count_rem == '0) begin
      nh_addr = bus.ar_addr;
      nh_len  = bus.ar_len;
      nh_id   = bus.ar_id;
      nh_lat  = cfg_rd_latency;
    end else begin
      nh_addr = fifo_addr[head_ptr];
      nh_len  = fifo_len[head_ptr];
      nh_id   = fifo_id[head_ptr];
      nh_lat  = fifo_lat[head_ptr];
    end
  end

  // Launch the first beat immediately for zero latency, else when the wait expires.
  assign launch  = (start && (nh_lat == '0)) || (wait_cnt == LAT_WIDTH'(1));
  assign l_addr  = start ? nh_addr : fifo_addr[rd_ptr];
  assign l_len   = start ? nh_len  : fifo_len[rd_ptr];
  assign l_id    = start ? nh_id   : fifo_id[rd_ptr];
  assign load    = launch || advance;
  assign rd_addr = launch ? l_addr : nxt_addr;

  // FIFO storage; latency is captured with the request.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.ar_addr;
      fifo_len[wr_ptr]  <= bus.ar_len;
      fifo_id[wr_ptr]   <= bus.ar_id;
      fifo_lat[wr_ptr]  <= cfg_rd_latency;
    end
  end

  // FIFO pointers, occupancy and head wait timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG_AR_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG_AR_DEPTH'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (start)                wait_cnt <= nh_lat;
      else if (wait_cnt != '0)  wait_cnt <= wait_cnt - LAT_WIDTH'(1);
    end
  end

  // Beat address walk within the active burst.
  always_ff @(posedge clk) begin
    if (launch) begin
      nxt_addr <= l_addr + ADDR_WIDTH'(1);
      beat_idx <= '0;
      cur_len  <= l_len;
    end else if (advance) begin
      nxt_addr <= nxt_addr + ADDR_WIDTH'(1);
      beat_idx <= beat_idx + 8'd1;
    end
  end

  // ---- stage p1: registered read beat, held until r_ready ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      resp_p1 <= 2'b00;
    end else begin
      if (load)             vld_p1 <= 1'b1;
      else if (bus.r_ready) vld_p1 <= 1'b0;
      if (launch)           last_p1 <= (l_len == 8'd0);
      else if (advance)     last_p1 <= ((beat_idx + 8'd1) == cur_len);
      else if (pop)         last_p1 <= 1'b0;
      if (load)             resp_p1 <= beat_err ? 2'b10 : 2'b00;
    end
  end

  // Beat payload; memory is read before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (load)   data_p1 <= beat_err ? '0 : mem[rd_addr];
    if (launch) id_p1   <= l_id;
  end

  assign bus.ar_ready = ar_ready_c;
  assign bus.r_valid  = vld_p1;
  assign bus.r_data   = data_p1;
  assign bus.r_id     = id_p1;
  assign bus.r_last   = last_p1;
  assign bus.r_resp   = resp_p1;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wstate_nx;
  end

  // Write FSM next-state logic.
  always_comb begin
    wstate_nx = wstate;
    unique case (wstate)
      W_IDLE:  if (bus.aw_valid)                wstate_nx = W_DATA;
      W_DATA:  if (bus.w_valid && bus.w_last)   wstate_nx = W_RESP;
      W_RESP:  if (bus.b_ready)                 wstate_nx = W_IDLE;
      default:                                  wstate_nx = W_IDLE;
    endcase
  end

  // Write FSM handshake outputs.
  always_comb begin
    aw_ready_w = (wstate == W_IDLE);
    w_ready_w  = (wstate == W_DATA);
    b_valid_w  = (wstate == W_RESP);
  end

  // Write address walk and response ID capture.
  always_ff @(posedge clk) begin
    if (bus.aw_valid && aw_ready_w) begin
      wr_addr <= bus.aw_addr;
      bid_q   <= bus.aw_id;
    end else if (bus.w_valid && w_ready_w) begin
      wr_addr <= wr_addr + ADDR_WIDTH'(1);
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.w_valid && w_ready_w) mem[wr_addr] <= bus.w_data;
  end

  assign bus.aw_ready = aw_ready_w;
  assign bus.w_ready  = w_ready_w;
  assign bus.b_valid  = b_valid_w;
  assign bus.b_id     = bid_q;
endmodule

// File: tb/tb_axi_lat_mem.sv
// Directed bench for axi_lat_mem with a read-beat scoreboard and a
// reference memory image built from the writes the bench performs.
`timescale 1ns/1ps
module tb_axi_lat_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] cfg_lat;
`ifdef AXI_LAT_MEM_ERR_INJ_EN
  logic [15:0] err_bar, err_limit;
`endif

  axi_lat_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .ID_WIDTH(8)) bus ();

  axi_lat_mem #(
    .DATA_WIDTH(8), .ADDR_WIDTH(16), .ID_WIDTH(8), .LOG_AR_DEPTH(2), .LAT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_rd_latency(cfg_lat),
`ifdef AXI_LAT_MEM_ERR_INJ_EN
    .err_bar(err_bar),
    .err_limit(err_limit),
`endif
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] id;
    logic       last;
    logic [1:0] resp;
  } beat_t;

  beat_t      sb [$];
  logic [7:0] ref_mem [0:65535];
  int         checks = 0;
  int         errors = 0;
  logic       hold_prev = 1'b0;
  logic [19:0] prev_beat = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: compare each read handshake and hold stability while stalled.
  always @(negedge clk) begin
    if (hold_prev)
      chk("r_hold", {bus.r_valid, bus.r_data, bus.r_id, bus.r_last, bus.r_resp}, prev_beat);
    if (!rst && bus.r_valid && bus.r_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        chk("r_beat", {bus.r_data, bus.r_id, bus.r_last, bus.r_resp}, sb[0]);
        sb.delete(0);
      end
    end
    hold_prev <= !rst && bus.r_valid && !bus.r_ready;
    prev_beat <= {bus.r_valid, bus.r_data, bus.r_id, bus.r_last, bus.r_resp};
  end

  task automatic do_write(input logic [15:0] addr, input logic [7:0] id,
                          input int n, input logic [7:0] d0);
    int k;
    logic [15:0] a;
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
    bus.aw_len   = 8'(n - 1);
    bus.aw_id    = id;
    k = 0;
    @(negedge clk);
    while (!bus.aw_ready && k < 100) begin @(negedge clk); k++; end
    chk("aw_timeout", k < 100, 1);
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = d0 + 8'(i);
      bus.w_last  = (i == n - 1);
      k = 0;
      @(negedge clk);
      while (!bus.w_ready && k < 100) begin @(negedge clk); k++; end
      chk("w_timeout", k < 100, 1);
      a = addr + 16'(i);
      ref_mem[a] = d0 + 8'(i);
      @(posedge clk); #1;
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
    bus.b_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.b_valid && k < 100) begin @(negedge clk); k++; end
    chk("b_timeout", k < 100, 1);
    chk("b_id", bus.b_id, id);
    @(posedge clk); #1;
    bus.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len,
                         input logic [7:0] id, input logic [3:0] lat);
    int k;
    logic [15:0] a;
    beat_t e;
    cfg_lat      = lat;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = addr;
    bus.ar_len   = len;
    bus.ar_id    = id;
    for (int i = 0; i <= int'(len); i++) begin
      a      = addr + 16'(i);
      e.id   = id;
      e.last = (i == int'(len));
`ifdef AXI_LAT_MEM_ERR_INJ_EN
      if ((a >= err_bar) && (a < err_limit)) begin
        e.data = ref_mem[a];
        e.resp = 2'b00;
      end else begin
        e.data = 8'h00;
        e.resp = 2'b10;
      end
`else
      e.data = ref_mem[a];
      e.resp = 2'b00;
`endif
      sb.push_back(e);
    end
    k = 0;
    @(negedge clk);
    while (!bus.ar_ready && k < 200) begin @(negedge clk); k++; end
    chk("ar_timeout", k < 200, 1);
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin @(negedge clk); k++; end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    cfg_lat = 4'd0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_id = '0;
    bus.r_ready  = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_id = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_last = 1'b0;
    bus.b_ready  = 1'b0;
`ifdef AXI_LAT_MEM_ERR_INJ_EN
    err_bar   = 16'h0000;
    err_limit = 16'hFFFF;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ar_ready", bus.ar_ready, 1);
    chk("rst_aw_ready", bus.aw_ready, 1);
    chk("rst_r_valid",  bus.r_valid,  0);
    chk("rst_b_valid",  bus.b_valid,  0);
    chk("rst_w_ready",  bus.w_ready,  0);
    chk("rst_r_last",   bus.r_last,   0);
    chk("rst_r_resp",   bus.r_resp,   0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three-beat write then read back with zero latency, no bubbles.
    do_write(16'h0EEF, 8'h5A, 3, 8'hAB);
    bus.r_ready = 1'b1;
    do_read(16'h0EEF, 8'd2, 8'h21, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("burst_consecutive", bus.r_valid, 1);
    end
    drain();

    // Latency 5: first r_valid six cycles after the acceptance cycle.
    do_write(16'h0200, 8'h33, 2, 8'h77);
    do_read(16'h0200, 8'd0, 8'h31, 4'd5);
    n = 1;
    @(negedge clk);
    while (!bus.r_valid && n < 50) begin @(negedge clk); n++; end
    chk("lat5_first_valid", n, 6);
    drain();

    // Latency 2: first r_valid three cycles after acceptance.
    do_read(16'h0201, 8'd0, 8'h32, 4'd2);
    n = 1;
    @(negedge clk);
    while (!bus.r_valid && n < 50) begin @(negedge clk); n++; end
    chk("lat2_first_valid", n, 3);
    drain();

    // Fill the request FIFO with r_ready low; fifth request waits for space.
    bus.r_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      do_read(16'h0EEF + 16'(i % 3), 8'd0, 8'(i), 4'(i % 2));
    @(negedge clk);
    chk("ar_ready_full", bus.ar_ready, 0);
    @(posedge clk); #1;
    bus.r_ready = 1'b1;
    do_read(16'h0EF1, 8'd0, 8'd5, 4'd0);
    drain();

    // Read burst wrapping past the top of the address space.
    do_write(16'hFFFF, 8'h44, 2, 8'h11);
    do_read(16'hFFFF, 8'd1, 8'h45, 4'd0);
    drain();

    // Reset in the middle of a four-beat burst.
    do_write(16'h0100, 8'h55, 4, 8'hC0);
    do_read(16'h0100, 8'd3, 8'h61, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.r_ready = 1'b0;
    @(negedge clk);
    chk("mid_burst_beats_left", sb.size(), 2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_r_valid",  bus.r_valid,  0);
    chk("post_rst_ar_ready", bus.ar_ready, 1);
    chk("post_rst_r_last",   bus.r_last,   0);
    sb.delete();
    @(posedge clk); #1;
    bus.r_ready = 1'b1;
    do_read(16'h0100, 8'd3, 8'h62, 4'd1);
    drain();

`ifdef AXI_LAT_MEM_ERR_INJ_EN
    // Second beat falls outside the allowed window.
    err_bar   = 16'h0000;
    err_limit = 16'h1DDE;
    do_write(16'h1DDD, 8'h70, 2, 8'h90);
    do_read(16'h1DDD, 8'd1, 8'h71, 4'd0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
